cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control unit for the 8-bit accumulator computer (PC, instruction memory, regA/regB, ALU).
- Owns the PC and a FETCH/EXEC/MEM state machine.
- Drives register load enables, ALU op and mux selects, and a req/ack handshake to data memory.
- Replaces the single-cycle hardwired decode so that slow data memory and conditional jumps on latched ALU flags are supported.

Parameters:
- AW, 8, PC / instruction-memory address width.
- IW, 15, instruction width; opcode = instr[IW-1:8] (7 bits), literal = instr[7:0].
- MEM_TIMEOUT, 16, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- instr  in  IW  instruction-memory read data for the current pc.
- alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flag outputs, combinational.
- mem_ack  in  1  data-memory ack; 1-cycle pulse completing a request.
- pc  out  AW  program counter to instruction memory.
- la, lb  out  1 each  regA / regB load enables.
- alu_op  out  3  ALU operation select.
- sel_b_lit  out  1  ALU B operand: 0 = regB, 1 = literal.
- sel_wb_mem  out  1  register write source: 0 = ALU, 1 = mem read data.
- lit  out  8  literal from the instruction register.
- mem_req, mem_we  out  1 each  memory request and write strobe.
- mem_addr  out  8  memory address (= literal).
- halted  out  1  sticky; high once HALT executes.
- fault  out  1  watchdog fault (tied 0 without the optional feature).

Behaviour:
- Reset (async, rst=1):
  - State = FETCH, pc = 0, IR = 0, flags {Z,N,C,V} = 0.
  - All outputs 0, including mem_req, which drops immediately even mid-handshake.
- Opcode fields:
  - [6:5] class: 00 ALU, 01 MEM, 10 JUMP, 11 SYS.
  - [4:2] alu_op, or jump condition for JUMP.
  - [1] dest: 0 = A, 1 = B.
  - [0] ALU: sel_b_lit. MEM: 1 = store, 0 = load. SYS: 1 = HALT, 0 = NOP.
- FETCH: IR <= instr; next state EXEC. All enables 0.
- EXEC, ALU class:
  - Drive alu_op and sel_b_lit; assert la or lb per dest.
  - Latch flags from alu_* at the cycle end.
  - pc <= pc+1; next state FETCH. Latency 2 cycles/instruction.
- EXEC, JUMP class:
  - Evaluate latched flags. 000 always, 001 Z, 010 !Z, 011 !Z&!N, 100 !N, 101 N, 110 N|Z, 111 C.
  - Taken: pc <= lit[AW-1:0], zero-extended if AW > 8. Not taken: pc <= pc+1.
  - Next state FETCH. Flags unchanged.
- EXEC, MEM class: next state MEM; no enables asserted this cycle.
- MEM:
  - Hold mem_req=1, mem_addr=lit, mem_we=store bit stable until mem_ack.
  - On the mem_ack cycle, for a load: sel_wb_mem=1 and la/lb per dest.
  - After the ack cycle: mem_req=0, pc <= pc+1, next state FETCH.
  - Ack on the first MEM cycle is legal; minimum MEM latency is 3 cycles/instruction.
  - mem_ack outside MEM is ignored.
- SYS:
  - NOP: pc+1, next state FETCH.
  - HALT: halted=1, state HALT, pc frozen. HALT exits only via rst.
- pc+1 wraps from 2^AW-1 to 0.
- la, lb, mem_req and mem_we are never asserted in FETCH or HALT. la and lb are never both 1.
- All control outputs are decoded from state+IR, not from instr. The instr input may change freely outside FETCH.

Optional Feature:
- Macro: CPU_SEQUENCER_WDOG_EN.
- With the macro:
  - A counter runs in MEM, cleared on entry to MEM.
  - If it reaches MEM_TIMEOUT without mem_ack: mem_req drops, fault=1 (sticky), halted=1, state HALT.
  - An ack arriving on the timeout cycle wins: normal completion, no fault.
- Without the macro: MEM waits indefinitely and fault is tied 0.

Decomposition:
- Package cpu_seq_pkg holds:
  - class encodings, jump condition codes, SYS sub-codes;
  - state enum (FETCH, EXEC, MEM, HALT);
  - the opcode field-slice constants.
- One sub-module, cpu_seq_decode: combinational. Maps IR opcode + state + flags to the control bundle (la, lb, alu_op, sel_b_lit, sel_wb_mem, mem_we, jump_taken).
- The FSM, PC, flag register and watchdog stay in cpu_sequencer.

Test Plan:
- Reset release, then ALU instr {7'b0000001, 8'h05} at pc 0 → cycle 1 FETCH; cycle 2 la=1, alu_op=000, sel_b_lit=1, lit=05; pc=1 after cycle 2.
- Flags Z=1 latched by an ALU op, then JEQ {7'b1000100, 8'h20} → pc=20. Same with Z=0 → pc=pc+1. JMP is taken regardless of flags.
- Load {7'b0100010, 8'h3A}, ack after 4 wait cycles → mem_req high 5 cycles, mem_addr=3A, mem_we=0; lb=1 and sel_wb_mem=1 only in the ack cycle. Store (bit0=1) → mem_we=1, no la/lb.
- rst asserted mid-MEM with mem_req=1 → mem_req=0 asynchronously; pc=0; restart fetch at 0.
- pc=FF (AW=8) executing NOP → pc=00. HALT {7'b1100001, 8'h00} → halted=1, pc frozen for 10 cycles, no enables.
- With CPU_SEQUENCER_WDOG_EN, MEM_TIMEOUT=16, no ack → after 16 MEM cycles fault=1, halted=1, mem_req=0. Ack on cycle 16 → no fault.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared encodings, field positions and bundles for the multi-cycle
// accumulator-machine sequencer (optional CPU_SEQUENCER_WDOG_EN watchdog).
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_MEM = 2'b01;
    localparam logic [1:0] CLS_JMP = 2'b10;
    localparam logic [1:0] CLS_SYS = 2'b11;

    localparam logic [2:0] JC_ALW = 3'b000;
    localparam logic [2:0] JC_Z   = 3'b001;
    localparam logic [2:0] JC_NZ  = 3'b010;
    localparam logic [2:0] JC_GT  = 3'b011;
    localparam logic [2:0] JC_NN  = 3'b100;
    localparam logic [2:0] JC_N   = 3'b101;
    localparam logic [2:0] JC_LE  = 3'b110;
    localparam logic [2:0] JC_C   = 3'b111;

    localparam logic SYS_NOP  = 1'b0;
    localparam logic SYS_HALT = 1'b1;

    localparam int OP_CLS_HI = 6;
    localparam int OP_CLS_LO = 5;
    localparam int OP_FN_HI  = 4;
    localparam int OP_FN_LO  = 2;
    localparam int OP_DEST   = 1;
    localparam int OP_B0     = 0;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    typedef struct packed {
        logic       la;
        logic       lb;
        logic [2:0] alu_op;
        logic       sel_b_lit;
        logic       sel_wb_mem;
        logic       mem_we;
        logic       jump_taken;
    } ctrl_t;

    function automatic logic jump_ok(input logic [2:0] cond,
                                     input flags_t f);
        logic t;
        t = 1'b0;
        unique case (cond)
            JC_ALW: t = 1'b1;
            JC_Z:   t = f.z;
            JC_NZ:  t = !f.z;
            JC_GT:  t = !f.z && !f.n;
            JC_NN:  t = !f.n;
            JC_N:   t = f.n;
            JC_LE:  t = f.n || f.z;
            JC_C:   t = f.c;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Data-memory request/acknowledge bus between sequencer and memory.
interface cpu_sequencer_if;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic       mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr,
        input  mem_ack
    );
    modport slave (
        input  mem_req, mem_we, mem_addr,
        output mem_ack
    );
endinterface

// File: rtl/cpu_seq_decode.sv
// Combinational control decode from state, latched opcode and flags.
module cpu_seq_decode
    import cpu_seq_pkg::*;
(
    input  state_t     st,
    input  logic [6:0] op,
    input  flags_t     fl,
    input  logic       mem_ack,
    output ctrl_t      ctrl
);
    logic [1:0] cls;
    logic [2:0] fn;
    logic       dest;
    logic       b0;
    logic       is_alu;
    logic       is_jmp;
    logic       is_mem;

    assign cls    = op[OP_CLS_HI:OP_CLS_LO];
    assign fn     = op[OP_FN_HI:OP_FN_LO];
    assign dest   = op[OP_DEST];
    assign b0     = op[OP_B0];
    assign is_alu = (st == EXEC) && (cls == CLS_ALU);
    assign is_jmp = (st == EXEC) && (cls == CLS_JMP);
    assign is_mem = (st == MEM);

    always_comb begin
        ctrl = '0;
        unique case (1'b1)
            is_alu: begin
                ctrl.alu_op    = fn;
                ctrl.sel_b_lit = b0;
                ctrl.la        = !dest;
                ctrl.lb        = dest;
            end
            is_jmp: ctrl.jump_taken = jump_ok(fn, fl);
            is_mem: begin
                ctrl.mem_we = b0;
                // load writes back only in the ack cycle
                if (mem_ack && !b0) begin
                    ctrl.sel_wb_mem = 1'b1;
                    ctrl.la         = !dest;
                    ctrl.lb         = dest;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/cpu_sequencer.sv
// FETCH/EXEC/MEM sequencer: PC, IR, flags and optional memory watchdog
// (enabled by defining CPU_SEQUENCER_WDOG_EN).
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int AW          = 8,
    parameter int IW          = 15,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IW-1:0]         instr,
    input  logic                  alu_z,
    input  logic                  alu_n,
    input  logic                  alu_c,
    input  logic                  alu_v,
    cpu_sequencer_if.master       mem,
    output logic [AW-1:0]         pc,
    output logic                  la,
    output logic                  lb,
    output logic [2:0]            alu_op,
    output logic                  sel_b_lit,
    output logic                  sel_wb_mem,
    output logic [7:0]            lit,
    output logic                  halted,
    output logic                  fault
);
    state_t        state, state_n;
    logic [AW-1:0] pc_n, pc_inc, pc_lit;
    logic [IW-1:0] ir, ir_n;
    flags_t        flags, flags_n;
    logic          halted_n;
    ctrl_t         ctrl;
    logic [6:0]    op;

    assign op     = ir[IW-1:8];
    assign lit    = ir[7:0];
    assign pc_inc = pc + AW'(1);
    assign pc_lit = AW'(lit);

    cpu_seq_decode u_dec (
        .st      (state),
        .op      (op),
        .fl      (flags),
        .mem_ack (mem.mem_ack),
        .ctrl    (ctrl)
    );

`ifdef CPU_SEQUENCER_WDOG_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] cnt, cnt_n;
    logic          fault_q, fault_n;
    assign fault = fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            fault_q <= fault_n;
        end
    end
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            flags  <= '0;
            halted <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            ir     <= ir_n;
            flags  <= flags_n;
            halted <= halted_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        ir_n     = ir;
        flags_n  = flags;
        halted_n = halted;
`ifdef CPU_SEQUENCER_WDOG_EN
        cnt_n    = cnt;
        fault_n  = fault_q;
`endif
        unique case (state)
            FETCH: begin
                ir_n    = instr;
                state_n = EXEC;
            end
            EXEC: begin
                unique case (op[OP_CLS_HI:OP_CLS_LO])
                    CLS_ALU: begin
                        flags_n = {alu_z, alu_n, alu_c, alu_v};
                        pc_n    = pc_inc;
                        state_n = FETCH;
                    end
                    CLS_MEM: begin
                        state_n = MEM;
`ifdef CPU_SEQUENCER_WDOG_EN
                        cnt_n   = '0;
`endif
                    end
                    CLS_JMP: begin
                        pc_n    = ctrl.jump_taken ? pc_lit : pc_inc;
                        state_n = FETCH;
                    end
                    default: begin
                        if (op[OP_B0] == SYS_HALT) begin
                            halted_n = 1'b1;
                            state_n  = HALT;
                        end else begin
                            pc_n    = pc_inc;
                            state_n = FETCH;
                        end
                    end
                endcase
            end
            MEM: begin
                // an ack on the timeout cycle still completes normally
                if (mem.mem_ack) begin
                    pc_n    = pc_inc;
                    state_n = FETCH;
                end
`ifdef CPU_SEQUENCER_WDOG_EN
                else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
                    fault_n  = 1'b1;
                    halted_n = 1'b1;
                    state_n  = HALT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
`endif
            end
            default: ;
        endcase
    end

    assign la           = ctrl.la;
    assign lb           = ctrl.lb;
    assign alu_op       = ctrl.alu_op;
    assign sel_b_lit    = ctrl.sel_b_lit;
    assign sel_wb_mem   = ctrl.sel_wb_mem;
    assign mem.mem_req  = (state == MEM);
    assign mem.mem_we   = ctrl.mem_we;
    assign mem.mem_addr = (state == MEM) ? lit : 8'h00;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Table-driven bench for cpu_sequencer with a next-pc scoreboard.
// Watchdog cases run only when CPU_SEQUENCER_WDOG_EN is defined.
module tb_cpu_sequencer;
    logic        clk;
    logic        rst;
    logic [14:0] instr;
    logic        alu_z, alu_n, alu_c, alu_v;
    logic [7:0]  pc;
    logic        la, lb;
    logic [2:0]  alu_op;
    logic        sel_b_lit, sel_wb_mem;
    logic [7:0]  lit;
    logic        halted, fault;

    cpu_sequencer_if mem_bus ();

    cpu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .mem        (mem_bus),
        .pc         (pc),
        .la         (la),
        .lb         (lb),
        .alu_op     (alu_op),
        .sel_b_lit  (sel_b_lit),
        .sel_wb_mem (sel_wb_mem),
        .lit        (lit),
        .halted     (halted),
        .fault      (fault)
    );

    typedef struct {
        logic [14:0] instr;
        logic [3:0]  flg;
        logic        la;
        logic        lb;
        logic [2:0]  op;
        logic        selb;
        logic        we;
        int          wt;
        logic [7:0]  pc_nx;
    } vec_t;

    vec_t       tbl[21];
    logic [7:0] sb[$];
    int         total = 0;
    int         bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // entered just after a negedge with the DUT in FETCH
    task automatic run_vec(input vec_t v);
        int   n;
        logic is_mem;
        logic ack;
        logic [7:0] e;
        is_mem = (v.instr[14:13] == 2'b01);
        instr = v.instr;
        {alu_z, alu_n, alu_c, alu_v} = v.flg;
        sb.push_back(v.pc_nx);
        #1;
        chk("fetch_quiet", {la, lb, mem_bus.mem_req, mem_bus.mem_we}, 0);
        @(negedge clk);
        instr = 15'($urandom);
        #1;
        chk("ex_la", la, is_mem ? 1'b0 : v.la);
        chk("ex_lb", lb, is_mem ? 1'b0 : v.lb);
        chk("ex_op", alu_op, v.op);
        chk("ex_selb", sel_b_lit, v.selb);
        chk("ex_req", {mem_bus.mem_req, mem_bus.mem_we}, 0);
        chk("ex_lit", lit, v.instr[7:0]);
        if (is_mem) begin
            n = 0;
            ack = 1'b0;
            while (!ack && n < 40) begin
                @(negedge clk);
                ack = (n == v.wt);
                mem_bus.mem_ack = ack;
                #1;
                chk("mem_req", mem_bus.mem_req, 1);
                chk("mem_addr", mem_bus.mem_addr, v.instr[7:0]);
                chk("mem_we", mem_bus.mem_we, v.we);
                chk("mem_la", la, ack ? v.la : 1'b0);
                chk("mem_lb", lb, ack ? v.lb : 1'b0);
                chk("mem_wb", sel_wb_mem, ack && !v.we);
                n++;
            end
            chk("mem_bound", ack, 1);
        end
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        #1;
        chk("back_req", mem_bus.mem_req, 0);
        chk("sb_nonempty", sb.size(), 1);
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk("pc_next", pc, e);
    endtask

    initial begin
        vec_t v;
        int   cnt;
        tbl[0]  = '{{7'b0000001, 8'h05}, 4'b1000, 1, 0, 3'd0, 1, 0, 0, 8'h01};
        tbl[1]  = '{{7'b1000100, 8'h20}, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 8'h20};
        tbl[2]  = '{{7'b0001110, 8'h07}, 4'b0000, 0, 1, 3'd3, 0, 0, 0, 8'h21};
        tbl[3]  = '{{7'b1000100, 8'h20}, 4'b1111, 0, 0, 3'd0, 0, 0, 0, 8'h22};
        tbl[4]  = '{{7'b1001000, 8'h40}, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 8'h40};
        tbl[5]  = '{{7'b1000000, 8'h10}, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 8'h10};
        tbl[6]  = '{{7'b0010100, 8'h99}, 4'b0100, 1, 0, 3'd5, 0, 0, 0, 8'h11};
        tbl[7]  = '{{7'b1010100, 8'h80}, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 8'h80};
        tbl[8]  = '{{7'b1010000, 8'h90}, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 8'h81};
        tbl[9]  = '{{7'b1011000, 8'h30}, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 8'h30};
        tbl[10] = '{{7'b0011111, 8'h01}, 4'b0010, 0, 1, 3'd7, 1, 0, 0, 8'h31};
        tbl[11] = '{{7'b1011100, 8'h05}, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 8'h05};
        tbl[12] = '{{7'b1001100, 8'h70}, 4'b1100, 0, 0, 3'd0, 0, 0, 0, 8'h70};
        tbl[13] = '{{7'b0100010, 8'h3A}, 4'b0000, 0, 1, 3'd0, 0, 0, 4, 8'h71};
        tbl[14] = '{{7'b0100001, 8'h55}, 4'b0000, 0, 0, 3'd0, 0, 1, 0, 8'h72};
        tbl[15] = '{{7'b0100000, 8'h11}, 4'b0000, 1, 0, 3'd0, 0, 0, 2, 8'h73};
        tbl[16] = '{{7'b1100000, 8'h00}, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 8'h74};
        tbl[17] = '{{7'b1000100, 8'h00}, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 8'h75};
        tbl[18] = '{{7'b1000000, 8'hFF}, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 8'hFF};
        tbl[19] = '{{7'b1100000, 8'h12}, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 8'h00};
        tbl[20] = '{{7'b1100000, 8'h00}, 4'b0000, 0, 0, 3'd0, 0, 0, 0, 8'h01};

        rst = 1'b1;
        instr = {7'b0100011, 8'hAA};
        {alu_z, alu_n, alu_c, alu_v} = 4'b0000;
        mem_bus.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_ctl", {la, lb, alu_op, sel_b_lit, sel_wb_mem}, 0);
        chk("rst_mem", {mem_bus.mem_req, mem_bus.mem_we,
                        mem_bus.mem_addr}, 0);
        chk("rst_lit", lit, 0);
        chk("rst_stat", {halted, fault}, 0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) run_vec(tbl[i]);

        // async reset while a load is waiting for ack
        instr = {7'b0100010, 8'hC3};
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_req", mem_bus.mem_req, 1);
        chk("mid_addr", mem_bus.mem_addr, 8'hC3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", mem_bus.mem_req, 0);
        chk("arst_pc", pc, 0);
        chk("arst_lit", lit, 0);
        @(negedge clk);
        rst = 1'b0;
        v = '{{7'b0000001, 8'h05}, 4'b0000, 1, 0, 3'd0, 1, 0, 0, 8'h01};
        run_vec(v);

        // HALT at pc 1: frozen, quiet, ack ignored
        instr = {7'b1100001, 8'h00};
        @(negedge clk);
        #1;
        chk("halt_ex", halted, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            instr = 15'($urandom);
            mem_bus.mem_ack = k[0];
            #1;
            chk("halt_flag", halted, 1);
            chk("halt_pc", pc, 8'h01);
            chk("halt_quiet", {la, lb, mem_bus.mem_req,
                               mem_bus.mem_we, sel_wb_mem}, 0);
        end
        mem_bus.mem_ack = 1'b0;

`ifdef CPU_SEQUENCER_WDOG_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("wd_rst", {halted, fault}, 0);
        instr = {7'b0100010, 8'h44};
        @(negedge clk);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (!mem_bus.mem_req) break;
            cnt++;
        end
        chk("wd_cycles", cnt, 16);
        chk("wd_fault", fault, 1);
        chk("wd_halt", halted, 1);
        chk("wd_req", mem_bus.mem_req, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("wd_clr", fault, 0);
        @(negedge clk);
        rst = 1'b0;
        v = '{{7'b0100000, 8'h66}, 4'b0000, 1, 0, 3'd0, 0, 0, 15, 8'h01};
        run_vec(v);
        chk("wd_late_ack", {fault, halted}, 0);
`else
        cnt = 0;
        chk("fault_tied", {fault, 31'(cnt)}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
